// File: rtl/dma_burst_controller.sv
// rtl/dma_burst_controller.sv - DMem <-> DDR DMA engine splitting transfers into INCR bursts
module dma_burst_controller #(
  parameter int AXI_AWIDTH  = 32,
  parameter int AXI_DWIDTH  = 32,
  parameter int DMEM_AWIDTH = 14,
  parameter int DMEM_DWIDTH = 32,
  parameter int MAX_BURST   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     dma_read_request_valid,
  input  logic                     dma_read_request_ready,
  output logic [AXI_AWIDTH-1:0]    dma_read_addr,
  output logic [31:0]              dma_read_len,
  output logic [2:0]               dma_read_size,
  output logic [1:0]               dma_read_burst,
  input  logic [AXI_DWIDTH-1:0]    dma_read_data,
  input  logic                     dma_read_data_valid,
  output logic                     dma_read_data_ready,
  output logic                     dma_write_request_valid,
  input  logic                     dma_write_request_ready,
  output logic [AXI_AWIDTH-1:0]    dma_write_addr,
  output logic [31:0]              dma_write_len,
  output logic [2:0]               dma_write_size,
  output logic [1:0]               dma_write_burst,
  output logic [AXI_DWIDTH-1:0]    dma_write_data,
  output logic                     dma_write_data_valid,
  input  logic                     dma_write_data_ready,
  input  logic                     dma_start,
  input  logic                     dma_dir,
  input  logic [31:0]              dma_src_addr,
  input  logic [31:0]              dma_dst_addr,
  input  logic [31:0]              dma_len,
  output logic                     dma_done,
  output logic                     dma_idle,
  output logic [31:0]              dma_xfer_cnt,
  output logic [DMEM_AWIDTH-1:0]   dmem_addr,
  output logic [DMEM_DWIDTH-1:0]   dmem_din,
  input  logic [DMEM_DWIDTH-1:0]   dmem_dout,
  output logic [DMEM_DWIDTH/8-1:0] dmem_wbe,
  output logic                     dmem_en
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_REQ  = 3'd1;
  localparam logic [2:0] S_RD_DATA = 3'd2;
  localparam logic [2:0] S_WR_REQ  = 3'd3;
  localparam logic [2:0] S_WR_DATA = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam int BCW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  logic [2:0]     state;
  logic [31:0]    src_q;
  logic [31:0]    dst_q;
  logic [31:0]    len_q;
  logic [31:0]    beat_cnt;
  logic [BCW-1:0] burst_cnt;
  logic           done_q;

  logic [31:0] remaining;
  logic [31:0] burst_len;
  logic        xfer_last;
  logic        burst_last;
  logic        rd_req_fire;
  logic        rd_data_fire;
  logic        wr_req_fire;
  logic        wr_data_fire;

  // A burst ends on the MAX_BURST-th beat or on the final word, whichever comes first.
  assign remaining  = len_q - beat_cnt;
  assign burst_len  = (remaining > 32'(MAX_BURST)) ? 32'(MAX_BURST) : remaining;
  assign xfer_last  = (beat_cnt + 32'd1) == len_q;
  assign burst_last = xfer_last || (burst_cnt == BCW'(MAX_BURST - 1));

  // Reset gates every handshake output combinationally so nothing leaks during the reset cycle.
  assign dma_read_request_valid  = !rst && (state == S_RD_REQ);
  assign dma_read_data_ready     = !rst && (state == S_RD_DATA);
  assign dma_write_request_valid = !rst && (state == S_WR_REQ);
  assign dma_write_data_valid    = !rst && (state == S_WR_DATA);

  assign rd_req_fire  = dma_read_request_valid && dma_read_request_ready;
  assign rd_data_fire = dma_read_data_ready && dma_read_data_valid;
  assign wr_req_fire  = dma_write_request_valid && dma_write_request_ready;
  assign wr_data_fire = dma_write_data_valid && dma_write_data_ready;

  assign dma_read_addr   = AXI_AWIDTH'(src_q + (beat_cnt << 2));
  assign dma_read_len    = burst_len - 32'd1;
  assign dma_read_size   = 3'd2;
  assign dma_read_burst  = BURST_INCR;
  assign dma_write_addr  = AXI_AWIDTH'(dst_q + (beat_cnt << 2));
  assign dma_write_len   = burst_len - 32'd1;
  assign dma_write_size  = 3'd2;
  assign dma_write_burst = BURST_INCR;
  assign dma_write_data  = dmem_dout;

  assign dmem_din     = dma_read_data;
  assign dma_done     = done_q;
  assign dma_idle     = (state == S_IDLE);
  assign dma_xfer_cnt = beat_cnt;

  // DMem port: write on read beats, prefetch the current word in WR_REQ and the next one on each write beat.
  always_comb begin
    dmem_en   = 1'b0;
    dmem_wbe  = '0;
    dmem_addr = DMEM_AWIDTH'(dst_q + beat_cnt);
    case (state)
      S_RD_DATA: begin
        dmem_en   = rd_data_fire;
        dmem_wbe  = {(DMEM_DWIDTH/8){rd_data_fire}};
        dmem_addr = DMEM_AWIDTH'(dst_q + beat_cnt);
      end
      S_WR_REQ: begin
        dmem_en   = !rst;
        dmem_addr = DMEM_AWIDTH'(src_q + beat_cnt);
      end
      S_WR_DATA: begin
        dmem_en   = wr_data_fire;
        dmem_addr = DMEM_AWIDTH'(src_q + beat_cnt + 32'd1);
      end
      default: begin
        dmem_en = 1'b0;
      end
    endcase
  end

  // Transfer sequencer: latch the job on start, then alternate request and data phases per burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      beat_cnt  <= '0;
      burst_cnt <= '0;
      done_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (dma_start) begin
            src_q     <= dma_src_addr;
            dst_q     <= dma_dst_addr;
            len_q     <= dma_len;
            beat_cnt  <= '0;
            burst_cnt <= '0;
            done_q    <= 1'b0;
            if (dma_len == 32'd0) begin
              state <= S_DONE;
            end else if (dma_dir) begin
              state <= S_WR_REQ;
            end else begin
              state <= S_RD_REQ;
            end
          end
        end
        S_RD_REQ: begin
          if (rd_req_fire) begin
            burst_cnt <= '0;
            state     <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (rd_data_fire) begin
            beat_cnt  <= beat_cnt + 32'd1;
            burst_cnt <= burst_cnt + 1'b1;
            if (burst_last) begin
              state <= xfer_last ? S_DONE : S_RD_REQ;
            end
          end
        end
        S_WR_REQ: begin
          if (wr_req_fire) begin
            burst_cnt <= '0;
            state     <= S_WR_DATA;
          end
        end
        S_WR_DATA: begin
          if (wr_data_fire) begin
            beat_cnt  <= beat_cnt + 32'd1;
            burst_cnt <= burst_cnt + 1'b1;
            if (burst_last) begin
              state <= xfer_last ? S_DONE : S_WR_REQ;
            end
          end
        end
        S_DONE: begin
          done_q <= 1'b1;
          state  <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/dma_burst_controller.md
Name: dma_burst_controller

Overview:
Next-generation DMA engine that moves 32-bit words between RISC-V DMem (port b) and off-chip DDR through the simplified AXI adapter read and write channels. Arbitrary-length transfers are split into consecutive INCR bursts of at most MAX_BURST beats, so long copies stay legal for AXI and bounded for the adapter. It sits between the Riscv151 IO-controller DMA registers and the AXI adapter, and exposes live progress to software.

Parameters:
AXI_AWIDTH, 32, DDR byte-address width
AXI_DWIDTH, 32, AXI data width; must equal DMEM_DWIDTH
DMEM_AWIDTH, 14, DMem word-address width
DMEM_DWIDTH, 32, DMem data width
MAX_BURST, 16, maximum beats per burst; power of 2, range 1..256

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
dma_read_request_valid  out  1  DDR read burst request
dma_read_request_ready  in  1  adapter accepts read request
dma_read_addr  out  AXI_AWIDTH  burst start byte address
dma_read_len  out  32  beats-1 of current burst
dma_read_size  out  3  constant 2 (4 bytes/beat)
dma_read_burst  out  2  constant BURST_INCR
dma_read_data  in  AXI_DWIDTH  read beat data
dma_read_data_valid  in  1  read beat valid
dma_read_data_ready  out  1  controller accepts read beat
dma_write_request_valid  out  1  DDR write burst request
dma_write_request_ready  in  1  adapter accepts write request
dma_write_addr  out  AXI_AWIDTH  burst start byte address
dma_write_len  out  32  beats-1 of current burst
dma_write_size  out  3  constant 2
dma_write_burst  out  2  constant BURST_INCR
dma_write_data  out  AXI_DWIDTH  write beat data (= dmem_dout)
dma_write_data_valid  out  1  write beat valid
dma_write_data_ready  in  1  adapter accepts write beat
dma_start  in  1  start pulse; sampled only in IDLE
dma_dir  in  1  1: DMem->DDR, 0: DDR->DMem
dma_src_addr  in  32  source (DDR byte addr or DMem word index)
dma_dst_addr  in  32  destination (DMem word index or DDR byte addr)
dma_len  in  32  total words
dma_done  out  1  sticky completion flag
dma_idle  out  1  high in IDLE
dma_xfer_cnt  out  32  words completed in current/last transfer
dmem_addr  out  DMEM_AWIDTH  DMem word address
dmem_din  out  DMEM_DWIDTH  = dma_read_data
dmem_dout  in  DMEM_DWIDTH  DMem read data, 1-cycle latency, holds when dmem_en=0
dmem_wbe  out  DMEM_DWIDTH/8  byte write enables
dmem_en  out  1  DMem port enable

Behaviour:
- Reset: state IDLE; all valids/readies 0; dma_done 0; dma_idle 1; dma_xfer_cnt 0; dmem_en 0; dmem_wbe 0. Reset mid-transfer abandons it immediately; no further requests or beats; DMem writes stop the same cycle.
- src, dst, len and dir are latched on an accepted start (IDLE & dma_start). dma_start outside IDLE is ignored. An accepted start clears dma_done and dma_xfer_cnt.
- Counters: beat_cnt (words done, driven on dma_xfer_cnt) and burst_cnt (beats in current burst). burst_len = min(len - beat_cnt, MAX_BURST); *_len = burst_len-1; request addr = base + 4*beat_cnt, 32-bit wrap.
- States: IDLE, RD_REQ, RD_DATA, WR_REQ, WR_DATA, DONE.
- IDLE: accepted start with len==0 -> DONE (no AXI activity). dir=0 -> RD_REQ. dir=1 -> WR_REQ.
- RD_REQ: read_request_valid=1 until fire. Fire -> RD_DATA with burst_cnt=0.
- RD_DATA: read_data_ready=1. Each fire: dmem_en=1, wbe=all ones, dmem_addr=dst+beat_cnt; beat_cnt++ and burst_cnt++. Last beat of burst: -> DONE if beat_cnt+1==len, else -> RD_REQ. No DMem access without fire.
- WR_REQ: write_request_valid=1; dmem_en=1, dmem_addr=src+beat_cnt (prefetch first word). Fire -> WR_DATA.
- WR_DATA: write_data_valid=1, data=dmem_dout. dmem_en=write_data_fire, dmem_addr=src+beat_cnt+1, so the next word is ready the cycle after the handshake. Without a fire dmem_dout is held stable. Burst end and completion follow the same rule as RD_DATA.
- DONE: one cycle; dma_done set (sticky); -> IDLE. dma_idle returns high the next cycle.
- Write completion is the last data-beat fire; the B response is handled by the adapter.
- dmem_addr is truncated to DMEM_AWIDTH.
- Only one request is outstanding at a time; the next burst request is issued only after the previous burst's last beat.

Test Plan:
- DDR->DMem, len=40, src=0x1000, dst=0x100, MAX_BURST=16, no backpressure -> three read requests (0x1000 len 15, 0x1040 len 15, 0x1080 len 7); DMem words 0x100..0x127 written in order; dma_done=1, dma_xfer_cnt=40.
- DMem->DDR, len=20, random write_data_ready stalls -> requests (dst len 15, dst+0x40 len 3); DDR beats match DMem[src..src+19] exactly, with no duplicated or skipped word across stalls.
- len=0, either dir -> no request valid ever asserted; dma_done=1 within 2 cycles of start; dma_xfer_cnt=0.
- len=16 (exactly MAX_BURST) and len=1 -> single request with len 15 / 0 respectively; correct data; done.
- dma_start pulsed during RD_DATA with a different len -> ignored; original transfer completes unchanged; the next start in IDLE clears dma_done.
- rst asserted at beat 5 of a write burst -> next cycle all valids 0, dma_idle=1, dma_done=0, dma_xfer_cnt=0; a subsequent start runs correctly.
